number_request_driver: RTL

- Initiator side of the go/number/result handshake used by the number-analyzer responders (e.g. the even-number checker).
- On a start command it walks a contiguous range of 32-bit numbers, issuing each one with a one-cycle go pulse.
- It captures the responder's 1-bit result after a fixed response latency, and tallies even, odd and mismatch counts.
- It sits between a control/host block and any fixed-latency number analyzer.

---
 rtl/number_analyzer_pkg.sv | 16 +
 rtl/parity_response_checker.sv | 59 +++++
 rtl/number_request_driver.sv | 131 +++++++++++++
 3 files changed

// File: rtl/number_analyzer_pkg.sv
// Shared types and defaults for the number-analyzer initiator, responders and benches.
package number_analyzer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StSample,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth       = 32;
  localparam int unsigned DefaultCntW        = 16;
  localparam int unsigned DefaultRespLatency = 3;

endpackage

// File: rtl/parity_response_checker.sv
// Compares a responder's even/odd verdict against the number's LSB and keeps the run tallies.
module parity_response_checker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             sample_i,
  input  logic             number_lsb_i,
  input  logic             result_i,
  output logic             expected_o,
  output logic [CNT_W-1:0] even_count_o,
  output logic [CNT_W-1:0] odd_count_o,
  output logic [CNT_W-1:0] err_count_o
);

  logic [CNT_W-1:0] even_q, even_d;
  logic [CNT_W-1:0] odd_q, odd_d;
  logic [CNT_W-1:0] err_q, err_d;

  assign expected_o = ~number_lsb_i;

  always_comb begin
    even_d = even_q;
    odd_d  = odd_q;
    err_d  = err_q;
    if (clear_i) begin
      even_d = '0;
      odd_d  = '0;
      err_d  = '0;
    end else if (sample_i) begin
      if (result_i) begin
        even_d = even_q + 1'b1;
      end else begin
        odd_d = odd_q + 1'b1;
      end
      if (result_i != expected_o) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      even_q <= '0;
      odd_q  <= '0;
      err_q  <= '0;
    end else begin
      even_q <= even_d;
      odd_q  <= odd_d;
      err_q  <= err_d;
    end
  end

  assign even_count_o = even_q;
  assign odd_count_o  = odd_q;
  assign err_count_o  = err_q;

endmodule

// File: rtl/number_request_driver.sv
// Initiator of the go/number/result handshake: walks a number range and tallies the verdicts
// returned by a fixed-latency responder.
module number_request_driver
  import number_analyzer_pkg::*;
#(
  parameter int unsigned WIDTH        = DefaultWidth,
  parameter int unsigned CNT_W        = DefaultCntW,
  parameter int unsigned RESP_LATENCY = DefaultRespLatency
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] start_num_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             go_o,
  output logic [WIDTH-1:0] number_o,
  input  logic             result_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] even_count_o,
  output logic [CNT_W-1:0] odd_count_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int unsigned WaitW = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] number_q, number_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             go_q, go_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clear;
  logic             sample;
  logic             expected;

  always_comb begin
    state_d     = state_q;
    number_d    = number_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    clear       = 1'b0;
    sample      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          number_d    = start_num_i;
          remaining_d = count_i;
          clear       = 1'b1;
          state_d     = (count_i != '0) ? StIssue : StDone;
        end
      end
      StIssue: begin
        wait_d  = WaitW'(RESP_LATENCY - 1);
        state_d = (RESP_LATENCY == 1) ? StSample : StWait;
      end
      StWait: begin
        wait_d = wait_q - 1'b1;
        // Leave when the decrement lands on zero so the item period is RESP_LATENCY+1.
        if (wait_q <= WaitW'(1)) begin
          state_d = StSample;
        end
      end
      StSample: begin
        sample      = 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == CNT_W'(1)) begin
          state_d = StDone;
        end else begin
          number_d = number_q + 1'b1;
          state_d  = StIssue;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    go_d   = (state_d == StIssue);
    busy_d = (state_d == StIssue) || (state_d == StWait) || (state_d == StSample);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      number_q    <= '0;
      remaining_q <= '0;
      wait_q      <= '0;
      go_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      number_q    <= number_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      go_q        <= go_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  parity_response_checker #(
    .CNT_W (CNT_W)
  ) u_checker (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (clear),
    .sample_i     (sample),
    .number_lsb_i (number_q[0]),
    .result_i     (result_i),
    .expected_o   (expected),
    .even_count_o (even_count_o),
    .odd_count_o  (odd_count_o),
    .err_count_o  (err_count_o)
  );

  assign go_o     = go_q;
  assign number_o = number_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

  logic unused_expected;
  assign unused_expected = expected;

endmodule
